alu_execute_unit: RTL and testbench

//   Execute stage directly downstream of the ALU decoder: consumes the 4-bit ALUControl code

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 29 ++
 rtl/alu_execute_unit.sv | 126 ++++++++++++
 tb/tb_alu_execute_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM states, op classification.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Shifts are the only ops that take the multi-cycle path.
  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: add/sub, compares and bitwise logic.
// Shift codes and unknown codes produce zero here; the execute unit handles shifts itself.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);

  // Select the single-cycle result for the current op code.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLT:  result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU: result = XLEN'(src_a < src_b);
      ALU_XOR:  result = src_a ^ src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_execute_unit.sv
// ALU execute stage: single-cycle ops through alu_core, shifts iterated SHIFT_STEP bits
// per cycle, valid/ready handshake on both sides with registered outputs.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [4:0]      RdIn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic [4:0]      RdOut
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  state_t              state, state_next;
  logic [XLEN-1:0]     work;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     core_result;
  logic [XLEN-1:0]     accept_result;
  logic [SHAMT_W-1:0]  remaining;
  logic [SHAMT_W-1:0]  step;
  logic [SHAMT_W-1:0]  shamt;
  logic [3:0]          shift_op;
  logic                accept;
  logic                start_shift;
  logic                last_step;

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_control (ALUControl),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .result      (core_result)
  );

  assign shamt         = SrcB[SHAMT_W-1:0];
  assign start_shift   = is_shift(ALUControl) && (shamt != '0);
  assign accept_result = is_shift(ALUControl) ? SrcA : core_result;
  assign last_step     = (remaining <= STEP);
  assign step          = last_step ? remaining : STEP;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);

  // One iteration of the shift in flight; SRA is the fall-through so it sign-fills.
  always_comb begin
    shifted = work;
    case (shift_op)
      ALU_SLL: shifted = work << step;
      ALU_SRL: shifted = work >> step;
      default: shifted = $signed(work) >>> step;
    endcase
  end

  // Next-state logic; flush overrides everything, including a same-cycle accept.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:  accept = in_valid;
      SHIFT: if (last_step) state_next = DONE;
      DONE: begin
        if (out_ready) begin
          accept = in_valid;
          if (!in_valid) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) state_next = start_shift ? SHIFT : DONE;
    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Shift work register, counter and output registers; a flush leaves them stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      remaining <= '0;
      shift_op  <= ALU_ADD;
      ALUResult <= '0;
      Zero      <= 1'b0;
      RdOut     <= '0;
    end else if (!flush) begin
      if (accept) begin
        RdOut <= RdIn;
        if (start_shift) begin
          work      <= SrcA;
          remaining <= shamt;
          shift_op  <= ALUControl;
        end else begin
          ALUResult <= accept_result;
          Zero      <= (accept_result == '0);
        end
      end else if (state == SHIFT) begin
        work      <= shifted;
        remaining <= remaining - step;
        if (last_step) begin
          ALUResult <= shifted;
          Zero      <= (shifted == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: two instances (SHIFT_STEP 1 and 4) checked every cycle
// against a transaction-level model, plus directed vectors with literal expectations.
module tb_alu_execute_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;

  logic        in_valid   [2];
  logic        in_ready   [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [31:0] alu_result [2];
  logic        zero       [2];
  logic [4:0]  rd_out     [2];

  int vec_count = 0;
  int err_count = 0;

  int          step_of [2];
  int          m_busy  [2];
  logic        m_vld   [2];
  logic [31:0] m_res   [2];
  logic [31:0] m_pres  [2];
  logic [4:0]  m_rd    [2];
  logic [4:0]  m_prd   [2];

  always #5 clk = ~clk;

  alu_execute_unit #(.XLEN(32), .SHIFT_STEP(1)) dut_step1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ALUControl(alu_control), .SrcA(src_a), .SrcB(src_b), .RdIn(rd_in),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .ALUResult(alu_result[0]), .Zero(zero[0]), .RdOut(rd_out[0])
  );

  alu_execute_unit #(.XLEN(32), .SHIFT_STEP(4)) dut_step4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ALUControl(alu_control), .SrcA(src_a), .SrcB(src_b), .RdIn(rd_in),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .ALUResult(alu_result[1]), .Zero(zero[1]), .RdOut(rd_out[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic straight from the op definitions; shifts done in one go.
  function automatic logic [31:0] model_result(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (code)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $signed(a) >>> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input int i);
    int k;
    logic [31:0] r;
    if (!rst_n) begin
      m_busy[i] = 0; m_vld[i] = 1'b0; m_res[i] = '0; m_rd[i] = '0;
    end else if (flush) begin
      m_busy[i] = 0; m_vld[i] = 1'b0;
    end else if (m_busy[i] > 0) begin
      m_busy[i]--;
      if (m_busy[i] == 0) begin
        m_vld[i] = 1'b1; m_res[i] = m_pres[i]; m_rd[i] = m_prd[i];
      end
    end else if (!m_vld[i] || out_ready[i]) begin
      if (in_valid[i]) begin
        r = model_result(alu_control, src_a, src_b);
        k = 0;
        if ((alu_control == 4'b0001 || alu_control == 4'b0101 || alu_control == 4'b1101) && src_b[4:0] != 5'd0)
          k = (int'(src_b[4:0]) + step_of[i] - 1) / step_of[i];
        if (k == 0) begin
          m_vld[i] = 1'b1; m_res[i] = r; m_rd[i] = rd_in;
        end else begin
          m_vld[i] = 1'b0; m_busy[i] = k; m_pres[i] = r; m_prd[i] = rd_in;
        end
      end else begin
        m_vld[i] = 1'b0;
      end
    end
  endtask

  // Advance the model on each edge, then compare both instances just after it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) modelStep(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_vld[i]));
      checkOutput($sformatf("in_ready[%0d]", i), 32'(in_ready[i]),
                  32'((m_busy[i] == 0) && (!m_vld[i] || out_ready[i])));
      if (m_vld[i]) begin
        checkOutput($sformatf("ALUResult[%0d]", i), alu_result[i], m_res[i]);
        checkOutput($sformatf("Zero[%0d]", i), 32'(zero[i]), 32'(m_res[i] == 32'd0));
        checkOutput($sformatf("RdOut[%0d]", i), 32'(rd_out[i]), 32'(m_rd[i]));
      end
    end
  end

  // Present one op to an instance and hold it until the handshake completes.
  task automatic applyStimulus(input int sel, input logic [3:0] code, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    bit accepted;
    accepted = 1'b0;
    alu_control = code; src_a = a; src_b = b; rd_in = rd;
    in_valid[sel] = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      accepted = in_ready[sel];
      @(posedge clk); #3;
    end
    in_valid[sel] = 1'b0;
    if (!accepted) begin
      vec_count++; err_count++;
      $display("[TB] FAIL accept timeout on instance %0d: got no in_ready, expected acceptance", sel);
    end
  endtask

  task automatic waitValid(input int sel, output int lat, output int ready_high);
    lat = 1;
    ready_high = 0;
    while (!out_valid[sel] && lat < 100) begin
      if (in_ready[sel]) ready_high++;
      @(posedge clk); #3;
      lat++;
    end
    if (!out_valid[sel]) begin
      vec_count++; err_count++;
      $display("[TB] FAIL result timeout on instance %0d: got out_valid=0, expected 1", sel);
    end
  endtask

  task automatic countValid(input int sel, input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #3;
      if (out_valid[sel]) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int lat, rh, seen;
    step_of[0] = 1; step_of[1] = 4;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_vld[i] = 1'b0; m_res[i] = '0; m_pres[i] = '0; m_rd[i] = '0; m_prd[i] = '0;
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    rst_n = 1'b0; flush = 1'b0;
    alu_control = 4'b0000; src_a = '0; src_b = '0; rd_in = '0;

    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("reset ALUResult", alu_result[0], 32'd0);
    checkOutput("reset Zero", 32'(zero[0]), 32'd0);
    checkOutput("reset RdOut", 32'(rd_out[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #3;

    applyStimulus(0, 4'b0000, 32'd7, 32'd5, 5'd1);
    checkOutput("ADD result", alu_result[0], 32'd12);
    checkOutput("ADD Zero", 32'(zero[0]), 32'd0);
    applyStimulus(0, 4'b1000, 32'd5, 32'd5, 5'd2);
    checkOutput("SUB back-to-back valid", 32'(out_valid[0]), 32'd1);
    checkOutput("SUB result", alu_result[0], 32'd0);
    checkOutput("SUB Zero", 32'(zero[0]), 32'd1);
    checkOutput("SUB RdOut", 32'(rd_out[0]), 32'd2);

    applyStimulus(0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd3);
    checkOutput("SLT result", alu_result[0], 32'd1);
    applyStimulus(0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd3);
    checkOutput("SLTU result", alu_result[0], 32'd0);
    applyStimulus(0, 4'b1001, 32'h0000_1234, 32'h0000_5678, 5'd3);
    checkOutput("illegal result", alu_result[0], 32'd0);
    checkOutput("illegal Zero", 32'(zero[0]), 32'd1);

    applyStimulus(0, 4'b1101, 32'h8000_0000, 32'd31, 5'd4);
    waitValid(0, lat, rh);
    checkOutput("SRA31 latency", 32'(lat), 32'd32);
    checkOutput("SRA31 in_ready high cycles", 32'(rh), 32'd0);
    checkOutput("SRA31 result", alu_result[0], 32'hFFFF_FFFF);
    checkOutput("SRA31 RdOut", 32'(rd_out[0]), 32'd4);

    applyStimulus(0, 4'b0001, 32'hA5A5_0001, 32'h0000_0020, 5'd5);
    waitValid(0, lat, rh);
    checkOutput("SLL0 latency", 32'(lat), 32'd1);
    checkOutput("SLL0 result", alu_result[0], 32'hA5A5_0001);

    applyStimulus(1, 4'b0101, 32'hF000_0000, 32'd4, 5'd6);
    waitValid(1, lat, rh);
    checkOutput("SRL4 step4 latency", 32'(lat), 32'd2);
    checkOutput("SRL4 step4 result", alu_result[1], 32'h0F00_0000);
    applyStimulus(1, 4'b0101, 32'hF000_0000, 32'd5, 5'd7);
    waitValid(1, lat, rh);
    checkOutput("SRL5 step4 latency", 32'(lat), 32'd3);
    checkOutput("SRL5 step4 result", alu_result[1], 32'h0780_0000);
    applyStimulus(1, 4'b1101, 32'h8000_0000, 32'd31, 5'd8);
    waitValid(1, lat, rh);
    checkOutput("SRA31 step4 latency", 32'(lat), 32'd9);
    checkOutput("SRA31 step4 result", alu_result[1], 32'hFFFF_FFFF);

    @(posedge clk); #3;
    out_ready[0] = 1'b0;
    applyStimulus(0, 4'b0000, 32'd1, 32'd2, 5'd7);
    alu_control = 4'b0100; src_a = 32'hFF00_FF00; src_b = 32'h0F0F_0F0F; rd_in = 5'd8;
    in_valid[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      checkOutput("stall out_valid", 32'(out_valid[0]), 32'd1);
      checkOutput("stall ALUResult", alu_result[0], 32'd3);
      checkOutput("stall RdOut", 32'(rd_out[0]), 32'd7);
      checkOutput("stall in_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk); #3;
    end
    out_ready[0] = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #3;
    in_valid[0] = 1'b0;
    checkOutput("queued XOR result", alu_result[0], 32'hF00F_F00F);
    checkOutput("queued XOR RdOut", 32'(rd_out[0]), 32'd8);

    @(posedge clk); #3;
    applyStimulus(0, 4'b0101, 32'h0000_0100, 32'd8, 5'd9);
    repeat (3) begin @(posedge clk); #3; end
    flush = 1'b1;
    @(posedge clk); #3;
    flush = 1'b0;
    checkOutput("flush in_ready", 32'(in_ready[0]), 32'd1);
    countValid(0, 40, seen);
    checkOutput("flush mid-shift valid count", 32'(seen), 32'd0);

    alu_control = 4'b0000; src_a = 32'd1; src_b = 32'd1; rd_in = 5'd12;
    in_valid[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #3;
    in_valid[0] = 1'b0; flush = 1'b0;
    countValid(0, 5, seen);
    checkOutput("flush with in_valid valid count", 32'(seen), 32'd0);

    applyStimulus(0, 4'b1101, 32'h8000_0000, 32'd20, 5'd10);
    repeat (3) begin @(posedge clk); #3; end
    rst_n = 1'b0;
    #1;
    checkOutput("reset pulse out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("reset pulse in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("reset pulse ALUResult", alu_result[0], 32'd0);
    checkOutput("reset pulse Zero", 32'(zero[0]), 32'd0);
    checkOutput("reset pulse RdOut", 32'(rd_out[0]), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    countValid(0, 40, seen);
    checkOutput("reset pulse valid count", 32'(seen), 32'd0);

    applyStimulus(0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd11);
    checkOutput("ADD wrap result", alu_result[0], 32'd0);
    checkOutput("ADD wrap Zero", 32'(zero[0]), 32'd1);
    checkOutput("ADD wrap RdOut", 32'(rd_out[0]), 32'd11);

    @(posedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
